// File: rtl/robot_step_scheduler.sv
// Step scheduler between a gamepad / wall-follow controller and the maze map.
// Issues at most one avancar/girar/remover pulse per tick and waits for map_ack.
module robot_step_scheduler #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       auto_mode,
    input  logic       btn_fwd,
    input  logic       btn_turn,
    input  logic       btn_remove,
    input  logic       head,
    input  logic       left,
    input  logic       under,
    input  logic       barrier,
    input  logic       map_ack,
    output logic       avancar,
    output logic       girar,
    output logic       remover,
    output logic       busy,
    output logic [2:0] state,
    output logic [9:0] step_count,
    output logic       done
);

    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECIDE   = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE   = 2'd0,
        CMD_FWD    = 2'd1,
        CMD_TURN   = 2'd2,
        CMD_REMOVE = 2'd3
    } cmd_t;

    state_t          state_reg, state_next;
    cmd_t            cmd_reg, cmd_next;
    logic [2:0]      pending_reg, pending_next;     // {remove, turn, fwd}
    logic [2:0]      btn_prev_reg;
    logic            auto_prev_reg;
    logic            turn_fwd_reg, turn_fwd_next;
    logic [1:0]      rt_cnt_reg, rt_cnt_next;
    logic [TW-1:0]   timeout_reg, timeout_next;
    logic [9:0]      step_count_reg, step_count_next;

    logic [2:0]      btn_now;
    logic [2:0]      btn_rise;
    logic            auto_rise;
    logic            auto_fall;
    logic            blocked;

    assign btn_now   = {btn_remove, btn_turn, btn_fwd};
    assign auto_rise = auto_mode & ~auto_prev_reg;
    assign auto_fall = ~auto_mode & auto_prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn_edge
            assign btn_rise[gi] = btn_now[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            cmd_reg        <= CMD_NONE;
            pending_reg    <= '0;
            btn_prev_reg   <= '0;
            auto_prev_reg  <= 1'b0;
            turn_fwd_reg   <= 1'b0;
            rt_cnt_reg     <= '0;
            timeout_reg    <= '0;
            step_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cmd_reg        <= cmd_next;
            pending_reg    <= pending_next;
            btn_prev_reg   <= btn_now;
            auto_prev_reg  <= auto_mode;
            turn_fwd_reg   <= turn_fwd_next;
            rt_cnt_reg     <= rt_cnt_next;
            timeout_reg    <= timeout_next;
            step_count_reg <= step_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cmd_next        = cmd_reg;
        pending_next    = pending_reg | btn_rise;
        turn_fwd_next   = turn_fwd_reg;
        rt_cnt_next     = rt_cnt_reg;
        timeout_next    = timeout_reg;
        step_count_next = step_count_reg;
        blocked         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (tick) state_next = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (!auto_mode) begin
                    // A fresh press arriving in the same cycle survives the clear.
                    state_next = ST_ISSUE;
                    if (pending_reg[2]) begin
                        cmd_next        = CMD_REMOVE;
                        pending_next[2] = btn_rise[2];
                    end else if (pending_reg[1]) begin
                        cmd_next        = CMD_TURN;
                        pending_next[1] = btn_rise[1];
                    end else if (pending_reg[0]) begin
                        cmd_next        = CMD_FWD;
                        pending_next[0] = btn_rise[0];
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (under) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_ISSUE;
                    if (rt_cnt_reg != 2'd0) begin
                        cmd_next    = CMD_TURN;
                        rt_cnt_next = rt_cnt_reg - 2'd1;
                    end else if (turn_fwd_reg) begin
                        turn_fwd_next = 1'b0;
                        if (!head) cmd_next = CMD_FWD;
                        else       blocked  = 1'b1;
                    end else if (!left) begin
                        cmd_next      = CMD_TURN;
                        turn_fwd_next = 1'b1;
                    end else if (!head) begin
                        cmd_next = CMD_FWD;
                    end else begin
                        blocked = 1'b1;
                    end
                    // Wall ahead: clear a barrier if possible, else start a right turn (3 lefts).
                    if (blocked) begin
                        if (barrier) begin
                            cmd_next = CMD_REMOVE;
                        end else begin
                            cmd_next    = CMD_TURN;
                            rt_cnt_next = 2'd2;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                timeout_next = '0;
                state_next   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (map_ack) begin
                    state_next = ST_IDLE;
                    if (step_count_reg != 10'd1023) step_count_next = step_count_reg + 10'd1;
                end else if (timeout_reg == TIMEOUT_LAST) begin
                    state_next    = ST_IDLE;
                    turn_fwd_next = 1'b0;
                    rt_cnt_next   = 2'd0;
                end else begin
                    timeout_next = timeout_reg + TW'(1);
                end
            end
            ST_DONE: begin
                if (!auto_mode) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (auto_rise) pending_next = '0;
        if (auto_fall) begin
            turn_fwd_next = 1'b0;
            rt_cnt_next   = 2'd0;
        end
    end

    assign avancar    = (state_reg == ST_ISSUE) && (cmd_reg == CMD_FWD);
    assign girar      = (state_reg == ST_ISSUE) && (cmd_reg == CMD_TURN);
    assign remover    = (state_reg == ST_ISSUE) && (cmd_reg == CMD_REMOVE);
    assign busy       = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_ACK);
    assign done       = (state_reg == ST_DONE);
    assign state      = state_reg;
    assign step_count = step_count_reg;

endmodule

// File: tb/tb_robot_step_scheduler.sv
// Directed bench for robot_step_scheduler: a vector table of single steps
// plus hand-written timeout, goal, tick-drop, reset and saturation sequences.
module tb_robot_step_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick, auto_mode, btn_fwd, btn_turn, btn_remove;
    logic       head, left, under, barrier, map_ack;
    logic       avancar, girar, remover, busy, done;
    logic [2:0] state;
    logic [9:0] step_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    localparam logic [2:0] P_NO = 3'b000;
    localparam logic [2:0] P_AV = 3'b100;
    localparam logic [2:0] P_GI = 3'b010;
    localparam logic [2:0] P_RM = 3'b001;
    localparam logic [2:0] B_FWD = 3'b001;
    localparam logic [2:0] B_TRN = 3'b010;
    localparam logic [2:0] B_REM = 3'b100;

    // sens = {head, left, under, barrier}
    typedef struct packed {
        logic       auto_m;
        logic [2:0] btns;
        logic [3:0] sens;
        logic [2:0] exp_p;
    } vec_t;

    vec_t vecs [12];

    robot_step_scheduler #(.ACK_TIMEOUT(255)) dut (
        .clock(clock), .reset(reset), .tick(tick), .auto_mode(auto_mode),
        .btn_fwd(btn_fwd), .btn_turn(btn_turn), .btn_remove(btn_remove),
        .head(head), .left(left), .under(under), .barrier(barrier),
        .map_ack(map_ack), .avancar(avancar), .girar(girar), .remover(remover),
        .busy(busy), .state(state), .step_count(step_count), .done(done)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] pulses();
        return {avancar, girar, remover};
    endfunction

    task automatic press(input logic [2:0] b);
        {btn_remove, btn_turn, btn_fwd} = b;
        cycle();
        {btn_remove, btn_turn, btn_fwd} = 3'b000;
        cycle();
    endtask

    task automatic do_step(input logic [2:0] exp_p, input bit exp_done);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        chk("decide_state", 32'(state), 32'd1);
        cycle();
        chk("pulse", 32'(pulses()), 32'(exp_p));
        if (exp_p != P_NO) begin
            chk("issue_busy", 32'(busy), 32'd1);
            cycle();
            chk("wait_state", 32'(state), 32'd3);
            chk("wait_pulse", 32'(pulses()), 32'd0);
            cycle();
            chk("wait_busy", 32'(busy), 32'd1);
            cycle();
            map_ack = 1'b1;
            cycle();
            map_ack = 1'b0;
            exp_count = (exp_count == 1023) ? 1023 : exp_count + 1;
            chk("ack_state", 32'(state), 32'd0);
            chk("ack_busy", 32'(busy), 32'd0);
            chk("step_count", 32'(step_count), 32'(exp_count));
        end else begin
            chk("no_cmd_state", 32'(state), exp_done ? 32'd4 : 32'd0);
        end
    endtask

    initial begin
        reset = 1'b0; tick = 0; auto_mode = 0; btn_fwd = 0; btn_turn = 0; btn_remove = 0;
        head = 0; left = 0; under = 0; barrier = 0; map_ack = 0;

        vecs[0]  = '{1'b0, B_FWD,         4'b0000, P_AV};
        vecs[1]  = '{1'b0, B_FWD | B_REM, 4'b0000, P_RM};
        vecs[2]  = '{1'b0, 3'b000,        4'b0000, P_AV};
        vecs[3]  = '{1'b0, 3'b000,        4'b0000, P_NO};
        vecs[4]  = '{1'b0, B_TRN,         4'b0000, P_GI};
        vecs[5]  = '{1'b1, 3'b000,        4'b1100, P_GI};
        vecs[6]  = '{1'b1, 3'b000,        4'b1100, P_GI};
        vecs[7]  = '{1'b1, 3'b000,        4'b1100, P_GI};
        vecs[8]  = '{1'b1, 3'b000,        4'b0000, P_GI};
        vecs[9]  = '{1'b1, 3'b000,        4'b0000, P_AV};
        vecs[10] = '{1'b1, 3'b000,        4'b0100, P_AV};
        vecs[11] = '{1'b1, 3'b000,        4'b1101, P_RM};

        cycle();
        cycle();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outs", 32'({pulses(), busy, done}), 32'd0);
        chk("reset_count", 32'(step_count), 32'd0);
        reset = 1'b1;
        cycle();

        for (int i = 0; i < 12; i++) begin
            auto_mode = vecs[i].auto_m;
            {head, left, under, barrier} = vecs[i].sens;
            cycle();
            if (vecs[i].btns != 3'b000) press(vecs[i].btns);
            do_step(vecs[i].exp_p, 1'b0);
            $display("vec %0d auto=%0d btns=%b sens=%b exp_pulse=%b step_count=%0d",
                     i, vecs[i].auto_m, vecs[i].btns, vecs[i].sens, vecs[i].exp_p, step_count);
        end

        // Tick while busy is dropped, not queued.
        auto_mode = 1'b0;
        cycle();
        press(B_FWD);
        tick = 1'b1; cycle(); tick = 1'b0;
        cycle();
        cycle();
        tick = 1'b1; cycle(); tick = 1'b0;
        map_ack = 1'b1; cycle(); map_ack = 1'b0;
        exp_count++;
        chk("drop_ack_count", 32'(step_count), 32'(exp_count));
        cycle();
        chk("drop_no_decide", 32'(state), 32'd0);
        $display("seq tick_drop state=%0d step_count=%0d", state, step_count);

        // Timeout after 255 cycles in WAIT_ACK, then a stray ack is ignored.
        press(B_FWD);
        tick = 1'b1; cycle(); tick = 1'b0;
        cycle();
        chk("to_pulse", 32'(pulses()), 32'(P_AV));
        cycle();
        repeat (254) cycle();
        chk("to_still_wait", 32'(state), 32'd3);
        cycle();
        chk("to_idle", 32'(state), 32'd0);
        chk("to_count", 32'(step_count), 32'(exp_count));
        map_ack = 1'b1; cycle(); map_ack = 1'b0;
        cycle();
        chk("stray_ack", 32'(step_count), 32'(exp_count));
        $display("seq timeout state=%0d step_count=%0d", state, step_count);

        // Timeout clears the right-turn counter.
        auto_mode = 1'b1; {head, left, under, barrier} = 4'b1100;
        cycle();
        tick = 1'b1; cycle(); tick = 1'b0;
        cycle();
        chk("rt_first_turn", 32'(pulses()), 32'(P_GI));
        repeat (256) cycle();
        chk("rt_timeout_idle", 32'(state), 32'd0);
        head = 1'b0;
        do_step(P_AV, 1'b0);
        $display("seq rt_clear step_count=%0d", step_count);

        // Goal reached.
        under = 1'b1;
        cycle();
        tick = 1'b1; cycle(); tick = 1'b0;
        cycle();
        chk("goal_state", 32'(state), 32'd4);
        chk("goal_done", 32'(done), 32'd1);
        tick = 1'b1; cycle(); tick = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("goal_quiet", 32'({pulses(), busy}), 32'd0);
            cycle();
        end
        chk("goal_hold", 32'(state), 32'd4);
        auto_mode = 1'b0; under = 1'b0;
        cycle();
        chk("goal_exit_state", 32'(state), 32'd0);
        chk("goal_exit_done", 32'(done), 32'd0);
        $display("seq goal state=%0d done=%0d", state, done);

        // Rising auto_mode clears latched presses.
        press(B_FWD);
        auto_mode = 1'b1; cycle();
        auto_mode = 1'b0; cycle();
        do_step(P_NO, 1'b0);
        $display("seq auto_rise_clear state=%0d", state);

        // Asynchronous reset in WAIT_ACK discards the command.
        press(B_FWD);
        tick = 1'b1; cycle(); tick = 1'b0;
        cycle();
        cycle();
        chk("rst_pre_wait", 32'(state), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_state", 32'(state), 32'd0);
        chk("rst_async_outs", 32'({pulses(), busy, done}), 32'd0);
        chk("rst_async_count", 32'(step_count), 32'd0);
        exp_count = 0;
        cycle();
        reset = 1'b1;
        cycle();
        map_ack = 1'b1; cycle(); map_ack = 1'b0;
        cycle();
        chk("rst_late_ack", 32'(step_count), 32'd0);
        chk("rst_late_state", 32'(state), 32'd0);
        $display("seq reset step_count=%0d", step_count);

        // Saturation at 1023.
        for (int n = 0; n < 1025; n++) begin
            press(B_FWD);
            do_step(P_AV, 1'b0);
        end
        chk("sat_count", 32'(step_count), 32'd1023);
        $display("seq saturate step_count=%0d", step_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/robot_step_scheduler.md
ROBOT_STEP_SCHEDULER -- requirements
Module: robot_step_scheduler

Interface
REQ-001 SHALL expose the following ports; clock and reset are first:
  clock  in  1  single system clock; all state changes on rising edge
  reset  in  1  asynchronous, active-low; 0 clears all state immediately
  tick  in  1  robot step strobe, one clock wide; at most one command is issued per tick
  auto_mode  in  1  1 = autonomous wall-follow, 0 = manual gamepad
  btn_fwd, btn_turn, btn_remove  in  1 each  raw gamepad levels, synchronous to clock
  head, left, under, barrier  in  1 each  map sensors: wall ahead, wall at left, robot on goal, removable barrier ahead
  map_ack  in  1  map has finished applying the last command
  avancar, girar, remover  out  1 each  one-cycle command pulses to the map; girar = 90 deg left turn
  busy  out  1  command outstanding (ISSUE or WAIT_ACK)
  state  out  3  FSM state code, for LEDs
  step_count  out  10  commands acknowledged, saturating
  done  out  1  goal reached in auto mode
REQ-002 SHALL use the parameter ACK_TIMEOUT (default 255), the cycles to wait for map_ack before abandoning a command.

Function
REQ-003 SHALL implement the FSM IDLE(0), DECIDE(1), ISSUE(2), WAIT_ACK(3), DONE(4); state SHALL drive this code.
REQ-004 In IDLE, a tick SHALL move to DECIDE; ticks seen in any other state SHALL be dropped and not queued.
REQ-005 The manual path SHALL rising-edge detect each button and latch it into a pending register; a latched bit SHALL stay set until its command is issued or auto_mode rises.
REQ-006 Manual DECIDE SHALL pick the pending command in priority remover > girar > avancar, clear only that bit, and go to ISSUE; with no bit pending it SHALL return to IDLE.
REQ-007 Auto DECIDE SHALL apply the left-hand rule in this order:
  - under=1: go to DONE.
  - turn_fwd flag set: issue avancar if head=0, else treat as head=1 below; the flag SHALL clear either way.
  - left=0: issue girar and set turn_fwd.
  - head=0: issue avancar.
  - barrier=1: issue remover.
  - otherwise: issue girar three times, one per tick, tracked by a 2-bit right-turn counter; this counter SHALL take precedence over all rules above except under.
REQ-008 ISSUE SHALL assert exactly one of avancar, girar or remover for exactly one cycle, then go to WAIT_ACK.
REQ-009 In WAIT_ACK:
  - map_ack=1: increment step_count (saturating at 1023) and go to IDLE.
  - ACK_TIMEOUT cycles without map_ack: go to IDLE with no increment, and clear the turn_fwd flag and the right-turn counter.
REQ-010 map_ack seen outside WAIT_ACK SHALL be ignored.
REQ-011 DONE SHALL hold done=1 and issue nothing; it SHALL leave to IDLE only when auto_mode=0 or reset is asserted.
REQ-012 A change of auto_mode while busy SHALL take effect at the next DECIDE; the outstanding command SHALL complete normally.
REQ-013 A rise of auto_mode SHALL clear the pending button register; a fall SHALL clear turn_fwd and the right-turn counter.
REQ-014 Sensors SHALL be sampled only in DECIDE; the command pulse SHALL appear two cycles after the tick (tick -> DECIDE -> ISSUE).

Reset
REQ-015 reset=0 SHALL force, without waiting for a clock edge: state=IDLE, all command pulses 0, busy=0, done=0, step_count=0, pending=0, turn_fwd=0, right-turn counter=0, timeout counter=0, button edge history=0.
REQ-016 reset asserted during WAIT_ACK SHALL discard the outstanding command; a later map_ack SHALL NOT increment step_count.

Verification
REQ-017 Manual: pulse btn_fwd then tick, map_ack 3 cycles later -> single-cycle avancar 2 cycles after the tick, busy=1 until the ack, step_count=1.
REQ-018 Manual priority: btn_fwd and btn_remove pressed together, two ticks each acked -> remover first, then avancar, step_count=2.
REQ-019 Auto: left=1, head=1, barrier=0, three ticks each acked -> three girar pulses and no avancar; then left=0 -> girar followed by avancar on the next tick.
REQ-020 Timeout: issue a command and withhold map_ack -> state returns to 0 after 255 cycles, step_count unchanged.
REQ-021 Auto goal: under=1 at a tick -> state=4, done=1, no pulses on further ticks; auto_mode=0 -> state=0, done=0.
REQ-022 Reset: assert reset=0 mid-WAIT_ACK, release, then pulse map_ack -> all outputs 0 and step_count stays 0.
